// File: rtl/div_unit.sv
// div_unit: iterative restoring divider with signed/unsigned modes.
// One quotient bit per cycle, MSB first. Divide-by-zero and the signed
// overflow case (MIN / -1) bypass the iteration and complete in one cycle
// with RISC-V style results. i_kill aborts the operation in flight.
//
// Handshake: a request is accepted on a rising edge where o_ready=1,
// i_start=1 and i_kill=0; operands and mode are captured on that edge.
// o_ready is high only in IDLE. o_valid is a one-cycle pulse in DONE, and
// the registered outputs are valid while it is high. There is no output
// back-pressure: the result must be taken when o_valid is high.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_kill,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [5:0]       CNT_LAST = 6'(WIDTH - 1);

    state_t r_state;
    state_t w_state_next;

    // In-flight operation
    logic [WIDTH-1:0] r_dsr;     // divisor magnitude
    logic [WIDTH-1:0] r_quo;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_rem;     // partial remainder
    logic             r_neg_q;   // quotient needs negation at the end
    logic             r_neg_r;   // remainder needs negation at the end
    logic [5:0]       r_cnt;     // iteration counter

    // Request decode
    logic             w_dvd_neg;
    logic             w_dsr_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic             w_div_zero;
    logic             w_overflow;
    logic             w_special;
    logic             w_accept;

    // Iteration step
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_quo_step;
    logic             w_last;
    logic             w_finish;
    logic [WIDTH-1:0] w_q_final;
    logic [WIDTH-1:0] w_r_final;

    // Decode the incoming request: magnitudes, sign fixes and special cases
    always_comb begin
        w_dvd_neg  = i_signed & i_dividend[WIDTH-1];
        w_dsr_neg  = i_signed & i_divisor[WIDTH-1];
        w_dvd_mag  = w_dvd_neg ? (~i_dividend + ONE) : i_dividend;
        w_dsr_mag  = w_dsr_neg ? (~i_divisor + ONE) : i_divisor;
        w_div_zero = (i_divisor == '0);
        w_overflow = i_signed && (i_dividend == MIN_INT) && (i_divisor == '1);
        w_special  = w_div_zero | w_overflow;
        w_accept   = (r_state == ST_IDLE) && i_start && !i_kill;
    end

    // One restoring shift-subtract step and the sign-corrected final result
    always_comb begin
        w_rem_shift = {r_rem, r_quo[WIDTH-1]};
        w_diff      = w_rem_shift - {1'b0, r_dsr};
        w_fits      = ~w_diff[WIDTH];
        w_rem_step  = w_fits ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
        w_quo_step  = {r_quo[WIDTH-2:0], w_fits};
        w_last      = (r_cnt == CNT_LAST);
        w_finish    = (r_state == ST_CALC) && !i_kill && w_last;
        w_q_final   = r_neg_q ? (~w_quo_step + ONE) : w_quo_step;
        w_r_final   = r_neg_r ? (~w_rem_step + ONE) : w_rem_step;
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (i_kill) begin
                    w_state_next = ST_IDLE;
                end else if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // A kill in DONE suppresses the pulse; IDLE follows either way
                o_valid      = !i_kill;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_dbg_state = r_state;

    // Operand capture and iteration registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dsr   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_dsr   <= w_dsr_mag;
            r_quo   <= w_dvd_mag;
            r_rem   <= '0;
            r_neg_q <= w_dvd_neg ^ w_dsr_neg;
            r_neg_r <= w_dvd_neg;
            r_cnt   <= '0;
        end else if (r_state == ST_CALC) begin
            if (i_kill) begin
                r_cnt <= '0;
            end else begin
                r_quo <= w_quo_step;
                r_rem <= w_rem_step;
                r_cnt <= w_last ? 6'd0 : r_cnt + 6'd1;
            end
        end
    end

    // Result registers: written only on entry to DONE, held otherwise
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_quotient  <= '0;
            o_remainder <= '0;
            o_div_zero  <= 1'b0;
        end else if (w_accept && w_div_zero) begin
            o_quotient  <= '1;
            o_remainder <= i_dividend;
            o_div_zero  <= 1'b1;
        end else if (w_accept && w_overflow) begin
            o_quotient  <= MIN_INT;
            o_remainder <= '0;
            o_div_zero  <= 1'b0;
        end else if (w_finish) begin
            o_quotient  <= w_q_final;
            o_remainder <= w_r_final;
            o_div_zero  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with a scoreboard queue and
// an independent monitor that checks every o_valid pulse.
module tb_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         i_rst;
  logic         i_start;
  logic         i_signed;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic         i_kill;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;
  logic         o_div_zero;
  logic [1:0]   o_dbg_state;

  div_unit #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_signed    (i_signed),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .i_kill      (i_kill),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_div_zero  (o_div_zero),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  // entry: {expected cycle[96:65], div_zero[64], quotient[63:32], remainder[31:0]}
  logic [96:0] exp_q[$];
  logic [96:0] mon_e;
  int total = 0;
  int bad = 0;
  int start_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: compare every result pulse against the head of the queue
  always @(negedge clk) begin
    if (!i_rst && o_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got o_valid=1 at cycle %0d expected no pulse", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("latency_cycle", 32'(cyc), mon_e[96:65]);
        chk("quotient", o_quotient, mon_e[63:32]);
        chk("remainder", o_remainder, mon_e[31:0]);
        chk("div_zero", {31'b0, o_div_zero}, {31'b0, mon_e[64]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks run in the phase 1 time unit after a rising edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input int lat, input bit want);
    int guard;
    guard = 0;
    while (!o_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!o_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got o_ready=0 expected 1");
    end
    i_start    = 1'b1;
    i_signed   = s;
    i_dividend = a;
    i_divisor  = b;
    start_cyc  = cyc;
    if (want) exp_q.push_back({32'(cyc + lat), edz, eq, er});
    @(posedge clk); #1;
    // scramble inputs after acceptance; the result must not depend on them
    i_start    = 1'b0;
    i_signed   = 1'($urandom_range(0, 1));
    i_dividend = $urandom;
    i_divisor  = $urandom;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((!o_ready || exp_q.size() != 0) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL result_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic no_valid(input int n);
    for (int i = 0; i < n; i++) begin
      chk("no_valid", {31'b0, o_valid}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_signed   = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    i_kill     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_quotient", o_quotient, 32'd0);
    chk("rst_remainder", o_remainder, 32'd0);
    chk("rst_div_zero", {31'b0, o_div_zero}, 32'd0);
    i_rst = 1'b0;
    @(posedge clk); #1;

    // unsigned 100/7 with busy window on o_ready
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1);
    for (int i = 1; i <= 33; i++) begin
      chk("ready_busy", {31'b0, o_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("ready_after", {31'b0, o_ready}, 32'd1);
    wait_idle();

    // signed and special-case vectors
    issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 1'b1);
    issue(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 33, 1'b1);
    issue(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b1);
    issue(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b1);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1, 1'b1);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 1'b1);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33, 1'b1);
    issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 33, 1'b1);
    issue(1'b0, 32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF, 1'b0, 33, 1'b1);
    issue(1'b1, 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0, 33, 1'b1);
    issue(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, 1'b1);
    wait_idle();

    // reset pulse in cycle 10 of a divide
    issue(1'b0, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    wait_to(start_cyc + 10);
    i_rst = 1'b1;
    #2;
    chk("midrst_ready", {31'b0, o_ready}, 32'd1);
    chk("midrst_valid", {31'b0, o_valid}, 32'd0);
    chk("midrst_quotient", o_quotient, 32'd0);
    chk("midrst_remainder", o_remainder, 32'd0);
    chk("midrst_div_zero", {31'b0, o_div_zero}, 32'd0);
    #1;
    i_rst = 1'b0;
    @(posedge clk); #1;
    no_valid(40);

    // ignored start in cycle 5, then a killed second divide
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1);
    wait_to(start_cyc + 5);
    i_start    = 1'b1;
    i_dividend = 32'd9;
    i_divisor  = 32'd3;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_idle();
    issue(1'b0, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    wait_to(start_cyc + 12);
    i_kill = 1'b1;
    @(posedge clk); #1;
    i_kill = 1'b0;
    chk("kill_ready_c13", {31'b0, o_ready}, 32'd1);
    chk("kill_hold_q", o_quotient, 32'd14);
    chk("kill_hold_r", o_remainder, 32'd2);
    no_valid(40);

    // kill and start together in IDLE: request is dropped
    i_start    = 1'b1;
    i_kill     = 1'b1;
    i_dividend = 32'd50;
    i_divisor  = 32'd5;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_kill  = 1'b0;
    chk("kill_start_ready", {31'b0, o_ready}, 32'd1);
    no_valid(40);

    // divider still works afterwards
    issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33, 1'b1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
